child_fanin_collector: RTL and testbench

CHILD_FANIN_COLLECTOR -- requirements
Module: child_fanin_collector

---
 rtl/child_fanin_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 56 +++++
 rtl/child_fanin_collector.sv | 111 +++++++++++
 tb/tb_child_fanin_collector.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/child_fanin_pkg.sv
// Package for the child fan-in collector.
// Holds default sizing parameters and the output-stage state encoding.
// Both are shared by the top level and the round-robin arbiter.
package child_fanin_pkg;

  localparam int NUM_CHILD_DEF = 5;
  localparam int DATA_W_DEF    = 8;
  localparam int SRC_W_DEF     = 3;

  // Output stage occupancy: EMPTY = no beat held, FULL = beat presented upstream
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the child fan-in collector.
// The search starts at r_ptr, wraps from NUM_CHILD-1 to 0, and grants the
// first requesting child. r_ptr then moves just past the winner.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (r_ptr -> 0)
//   req       : per-child request (child valid)
//   en        : grant enable; when low, gnt is all zero and r_ptr holds
//   gnt       : one-hot grant (combinational)
//   gnt_idx   : index of the granted child (combinational, 0 when no grant)
module rr_arbiter
  import child_fanin_pkg::*;
#(
  parameter int NUM_CHILD = NUM_CHILD_DEF,
  parameter int SRC_W     = SRC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CHILD-1:0] req,
  input  logic                 en,
  output logic [NUM_CHILD-1:0] gnt,
  output logic [SRC_W-1:0]     gnt_idx
);

  logic [SRC_W-1:0] r_ptr;
  logic [SRC_W:0]   w_pos;
  logic             w_found;

  // Scan NUM_CHILD positions starting at r_ptr; the extra bit in w_pos
  // absorbs the overflow before the wrap subtraction.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      w_pos = {1'b0, r_ptr} + (SRC_W+1)'(k);
      if (w_pos >= (SRC_W+1)'(NUM_CHILD)) begin
        w_pos = w_pos - (SRC_W+1)'(NUM_CHILD);
      end
      if (en && !w_found && req[w_pos[SRC_W-1:0]]) begin
        w_found                  = 1'b1;
        gnt[w_pos[SRC_W-1:0]]    = 1'b1;
        gnt_idx                  = w_pos[SRC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (gnt_idx == SRC_W'(NUM_CHILD-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/child_fanin_collector.sv
// Child fan-in collector: merges NUM_CHILD valid/ready child channels into
// one registered upstream channel, choosing among children round-robin.
//
// Handshake rule (all channels): a beat transfers in a cycle only when both
// valid and ready are high at the rising clock edge; valid never waits on
// ready, and a presented upstream beat holds stable until accepted.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-child valid
//   in_data    : per-child payload, child i at [i*DATA_W +: DATA_W]
//   in_ready   : per-child accept (combinational, one-hot or zero)
//   out_valid  : upstream valid (registered, equals state == FULL)
//   out_ready  : upstream accept
//   out_data   : registered payload
//   out_src    : registered index of the child that supplied out_data
//   beat_cnt   : saturating count of upstream handshakes
//   dbg_state  : output stage state, for observation
module child_fanin_collector
  import child_fanin_pkg::*;
#(
  parameter int NUM_CHILD = NUM_CHILD_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SRC_W     = SRC_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHILD-1:0]        in_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] in_data,
  output logic [NUM_CHILD-1:0]        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  output logic [15:0]                 beat_cnt,
  output state_t                      dbg_state
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_data;
  logic [SRC_W-1:0]    r_src;
  logic [15:0]         r_beat_cnt;

  logic                w_load_ok;
  logic                w_arb_en;
  logic                w_load;
  logic [NUM_CHILD-1:0] w_gnt;
  logic [SRC_W-1:0]    w_gnt_idx;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_drain;

  // The register can take a new beat when empty, or when the held beat
  // leaves in this same cycle. Reset blocks all grants.
  assign w_load_ok = (r_state == EMPTY) || out_ready;
  assign w_arb_en  = w_load_ok && !rst;
  assign w_drain   = (r_state == FULL) && out_ready;

  rr_arbiter #(
    .NUM_CHILD (NUM_CHILD),
    .SRC_W     (SRC_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_load = |w_gnt;

  // One-hot mux of the winner's payload
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (w_gnt[i]) begin
        w_sel_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_data     <= '0;
      r_src      <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_load) r_state <= FULL;
        FULL:  if (out_ready && !w_load) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
      if (w_load) begin
        r_data <= w_sel_data;
        r_src  <= w_gnt_idx;
      end
      if (w_drain && (r_beat_cnt != 16'hFFFF)) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  assign in_ready  = w_gnt;
  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign beat_cnt  = r_beat_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_child_fanin_collector.sv
module tb_child_fanin_collector;
  import child_fanin_pkg::*;

  localparam int NC = 5;
  localparam int DW = 8;
  localparam int SW = 3;

  logic            clk;
  logic            rst;
  logic [NC-1:0]   in_valid;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]   in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic [15:0]     beat_cnt;
  state_t          dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SW+DW-1:0] exp_q[$];

  child_fanin_collector #(
    .NUM_CHILD (NC),
    .DATA_W    (DW),
    .SRC_W     (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .beat_cnt  (beat_cnt),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_child(input int i, input logic [DW-1:0] v);
    in_data[i*DW +: DW] = v;
  endtask

  task automatic push_exp(input logic [SW-1:0] src, input logic [DW-1:0] d);
    exp_q.push_back({src, d});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: every upstream handshake pops one expectation
  always @(negedge clk) begin
    logic [SW+DW-1:0] e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected actual src=%0d data=%0h expected none", out_src, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_src, out_data} !== e) begin
          errors++;
          $display("FAIL beat actual src=%0d data=%0h expected src=%0d data=%0h",
                   out_src, out_data, e[SW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    // Reset with all children valid: nothing may be accepted
    rst       = 1'b1;
    in_valid  = 5'b11111;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) set_child(i, 8'h10 + 8'(i));
    repeat (3) step();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_src", 32'(out_src), 32'h0);
    step();
    rst      = 1'b0;
    in_valid = '0;
    step();

    // All children valid, out_ready high: 0,1,2,3,4,0,1,2,3,4 back to back
    for (int k = 0; k < 10; k++) push_exp(SW'(k % 5), 8'h10 + 8'(k % 5));
    in_valid = 5'b11111;
    @(negedge clk);
    check("first_grant_child0", 32'(in_ready), 32'h01);
    repeat (10) step();
    in_valid = '0;
    repeat (3) step();
    @(negedge clk);
    check("rr_beat_cnt", 32'(beat_cnt), 32'd10);
    check("rr_idle_valid", 32'(out_valid), 32'h0);

    // Child 3 alone, upstream stalled for 4 cycles
    step();
    in_valid  = 5'b01000;
    set_child(3, 8'hA5);
    out_ready = 1'b0;
    push_exp(3'd3, 8'hA5);
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_data", 32'(out_data), 32'hA5);
      check("stall_src", 32'(out_src), 32'h3);
      check("stall_in_ready", 32'(in_ready), 32'h0);
      check("stall_state", 32'(dbg_state), 32'(FULL));
      step();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("stall_beat_cnt", 32'(beat_cnt), 32'd11);
    check("stall_drained", 32'(out_valid), 32'h0);

    // Move ptr to 2 via child 1, then children 1 and 4: 4 wins, then 1
    step();
    in_valid = 5'b00010;
    set_child(1, 8'h31);
    push_exp(3'd1, 8'h31);
    step();
    in_valid = 5'b10010;
    set_child(4, 8'h44);
    push_exp(3'd4, 8'h44);
    push_exp(3'd1, 8'h31);
    @(negedge clk);
    check("wrap_grant4", 32'(in_ready), 32'h10);
    step();
    @(negedge clk);
    check("wrap_grant1", 32'(in_ready), 32'h02);
    step();
    in_valid = '0;
    step();
    step();
    @(negedge clk);
    check("wrap_beat_cnt", 32'(beat_cnt), 32'd14);

    // Drain and load in the same cycle, no bubble
    step();
    in_valid  = 5'b00100;
    set_child(2, 8'h22);
    out_ready = 1'b0;
    push_exp(3'd2, 8'h22);
    step();
    set_child(2, 8'h77);
    @(negedge clk);
    check("full_stall_in_ready", 32'(in_ready), 32'h0);
    step();
    out_ready = 1'b1;
    push_exp(3'd2, 8'h77);
    @(negedge clk);
    check("full_load_in_ready", 32'(in_ready), 32'h04);
    check("full_before_state", 32'(dbg_state), 32'(FULL));
    step();
    in_valid = '0;
    @(negedge clk);
    check("full_after_state", 32'(dbg_state), 32'(FULL));
    check("full_after_valid", 32'(out_valid), 32'h1);
    check("full_after_data", 32'(out_data), 32'h77);
    step();
    step();
    @(negedge clk);
    check("full_beat_cnt", 32'(beat_cnt), 32'd16);
    check("full_empty_state", 32'(dbg_state), 32'(EMPTY));

    // Reset while FULL and stalled: pending beat discarded
    step();
    in_valid  = 5'b01000;
    set_child(3, 8'h5A);
    out_ready = 1'b0;
    step();
    step();
    rst      = 1'b1;
    in_valid = 5'b11001;
    set_child(0, 8'h01);
    set_child(4, 8'h04);
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    push_exp(3'd0, 8'h01);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_beat_cnt", 32'(beat_cnt), 32'h0);
    check("midrst_grant0", 32'(in_ready), 32'h01);
    step();
    in_valid = '0;
    step();
    step();
    @(negedge clk);
    check("midrst_after_cnt", 32'(beat_cnt), 32'd1);

    // Saturation: preload 0xFFFE, then 3 handshakes
    force dut.r_beat_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_beat_cnt;
    check("sat_preload", 32'(beat_cnt), 32'hFFFE);
    step();
    in_valid = 5'b00001;
    set_child(0, 8'h0C);
    for (int k = 0; k < 3; k++) push_exp(3'd0, 8'h0C);
    repeat (3) step();
    in_valid = '0;
    step();
    step();
    @(negedge clk);
    check("sat_beat_cnt", 32'(beat_cnt), 32'hFFFF);
    check("sat_idle", 32'(out_valid), 32'h0);

    check("exp_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
